// File: rtl/csr_trap_ctrl_if.sv
// Trap-sequencer bus: execute-side trap handshake, CSR file port, fetch redirect and stall.
// The controller connects through the slave modport; execute/CSR/fetch side uses master.
interface csr_trap_ctrl_if #(
  parameter int CSR_AW = 12
);
  logic              trap_valid;
  logic [1:0]        trap_type;
  logic [31:0]       trap_pc;
  logic              trap_ready;
  logic [CSR_AW-1:0] csr_rd_addr;
  logic [31:0]       csr_rd_data;
  logic              csr_wr_en;
  logic [CSR_AW-1:0] csr_wr_addr;
  logic [31:0]       csr_wr_data;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              stall;

  modport slave (
    input  trap_valid, trap_type, trap_pc, csr_rd_data,
    output trap_ready, csr_rd_addr, csr_wr_en, csr_wr_addr, csr_wr_data,
           redirect_valid, redirect_pc, stall
  );

  modport master (
    output trap_valid, trap_type, trap_pc, csr_rd_data,
    input  trap_ready, csr_rd_addr, csr_wr_en, csr_wr_addr, csr_wr_data,
           redirect_valid, redirect_pc, stall
  );
endinterface

// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap sequencer: ecall/ebreak/mret -> CSR read/write sequence -> PC redirect.
// Optional TRAP_MTVAL_EN adds a T_TVAL state writing mtval on the trap path.
module csr_trap_ctrl #(
  parameter int          CSR_AW        = 12,
  parameter logic [31:0] MCAUSE_ECALL  = 32'd11,
  parameter logic [31:0] MCAUSE_EBREAK = 32'd3
) (
  input logic               clk,
  input logic               rst,
  csr_trap_ctrl_if.slave    bus
);

  localparam logic [CSR_AW-1:0] A_MSTATUS = CSR_AW'(12'h300);
  localparam logic [CSR_AW-1:0] A_MTVEC   = CSR_AW'(12'h305);
  localparam logic [CSR_AW-1:0] A_MEPC    = CSR_AW'(12'h341);
  localparam logic [CSR_AW-1:0] A_MCAUSE  = CSR_AW'(12'h342);
`ifdef TRAP_MTVAL_EN
  localparam logic [CSR_AW-1:0] A_MTVAL   = CSR_AW'(12'h343);
`endif

  typedef enum logic [1:0] {
    TT_NONE   = 2'b00,
    TT_ECALL  = 2'b01,
    TT_EBREAK = 2'b10,
    TT_MRET   = 2'b11
  } trap_type_t;

  typedef enum logic [3:0] {
    IDLE,
    T_EPC,
    T_CAUSE,
`ifdef TRAP_MTVAL_EN
    T_TVAL,
`endif
    T_STATUS,
    T_VEC,
    R_STATUS,
    R_EPC,
    REDIR
  } state_t;

  state_t            state, state_d;
  logic [31:0]       lat_pc;
  logic [1:0]        lat_type;
  logic [31:0]       target, target_d;
  logic              accept;
  logic              wr_en_c;
  logic [CSR_AW-1:0] wr_addr_c;
  logic [31:0]       wr_data_c;
  logic              redir_c;
  logic [31:0]       mstatus_new;

  assign bus.trap_ready = (state == IDLE);
  assign accept = bus.trap_valid && (state == IDLE) && (bus.trap_type != TT_NONE);
  assign bus.stall = (state != IDLE) || (bus.trap_valid && (bus.trap_type != TT_NONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lat_pc   <= '0;
      lat_type <= '0;
      target   <= '0;
    end else begin
      state  <= state_d;
      target <= target_d;
      if (accept) begin
        lat_pc   <= bus.trap_pc;
        lat_type <= bus.trap_type;
      end
    end
  end

  always_comb begin
    state_d         = state;
    target_d        = target;
    bus.csr_rd_addr = '0;
    wr_en_c         = 1'b0;
    wr_addr_c       = '0;
    wr_data_c       = '0;
    redir_c         = 1'b0;
    mstatus_new     = bus.csr_rd_data;
    unique case (state)
      IDLE: begin
        if (accept)
          state_d = (bus.trap_type == TT_MRET) ? R_STATUS : T_EPC;
      end
      T_EPC: begin
        wr_en_c   = 1'b1;
        wr_addr_c = A_MEPC;
        wr_data_c = lat_pc;
        state_d   = T_CAUSE;
      end
      T_CAUSE: begin
        wr_en_c   = 1'b1;
        wr_addr_c = A_MCAUSE;
        wr_data_c = (lat_type == TT_EBREAK) ? MCAUSE_EBREAK : MCAUSE_ECALL;
`ifdef TRAP_MTVAL_EN
        state_d   = T_TVAL;
`else
        state_d   = T_STATUS;
`endif
      end
`ifdef TRAP_MTVAL_EN
      T_TVAL: begin
        wr_en_c   = 1'b1;
        wr_addr_c = A_MTVAL;
        wr_data_c = (lat_type == TT_EBREAK) ? lat_pc : '0;
        state_d   = T_STATUS;
      end
`endif
      // Read-modify-write in one cycle: combinational read, write commits at the edge.
      T_STATUS: begin
        bus.csr_rd_addr    = A_MSTATUS;
        mstatus_new[7]     = bus.csr_rd_data[3];
        mstatus_new[3]     = 1'b0;
        mstatus_new[12:11] = 2'b11;
        wr_en_c            = 1'b1;
        wr_addr_c          = A_MSTATUS;
        wr_data_c          = mstatus_new;
        state_d            = T_VEC;
      end
      T_VEC: begin
        bus.csr_rd_addr = A_MTVEC;
        target_d        = {bus.csr_rd_data[31:2], 2'b00};
        state_d         = REDIR;
      end
      R_STATUS: begin
        bus.csr_rd_addr    = A_MSTATUS;
        mstatus_new[3]     = bus.csr_rd_data[7];
        mstatus_new[7]     = 1'b1;
        mstatus_new[12:11] = 2'b11;
        wr_en_c            = 1'b1;
        wr_addr_c          = A_MSTATUS;
        wr_data_c          = mstatus_new;
        state_d            = R_EPC;
      end
      R_EPC: begin
        bus.csr_rd_addr = A_MEPC;
        target_d        = bus.csr_rd_data;
        state_d         = REDIR;
      end
      REDIR: begin
        redir_c = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset suppresses the write/redirect of the state being abandoned at this edge.
  assign bus.csr_wr_en      = wr_en_c && !rst;
  assign bus.csr_wr_addr    = (wr_en_c && !rst) ? wr_addr_c : '0;
  assign bus.csr_wr_data    = (wr_en_c && !rst) ? wr_data_c : '0;
  assign bus.redirect_valid = redir_c && !rst;
  assign bus.redirect_pc    = (redir_c && !rst) ? target : '0;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Self-checking bench for csr_trap_ctrl: CSR file + reference model of CSR effects and timing.
module tb_csr_trap_ctrl;

  localparam logic [11:0] MSTATUS = 12'h300;
  localparam logic [11:0] MTVEC   = 12'h305;
  localparam logic [11:0] MEPC    = 12'h341;
  localparam logic [11:0] MCAUSE  = 12'h342;
  localparam logic [11:0] MTVAL   = 12'h343;
`ifdef TRAP_MTVAL_EN
  localparam int TRAP_LAT = 6;
`else
  localparam int TRAP_LAT = 5;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csr_trap_ctrl_if #(.CSR_AW(12)) bus ();

  csr_trap_ctrl #(
    .CSR_AW       (12),
    .MCAUSE_ECALL (32'd11),
    .MCAUSE_EBREAK(32'd3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // CSR file seen by the DUT, plus a poke path for the bench to preload values.
  logic [31:0] csr_mem [0:4095];
  logic        pre_en = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [31:0] pre_data = '0;
  logic [11:0] wr_log_a [$];
  logic [31:0] wr_log_d [$];
  int          gate_viol = 0;

  assign bus.csr_rd_data = csr_mem[bus.csr_rd_addr];

  always @(posedge clk) begin
    if (pre_en) csr_mem[pre_addr] <= pre_data;
    else if (bus.csr_wr_en) begin
      csr_mem[bus.csr_wr_addr] <= bus.csr_wr_data;
      wr_log_a.push_back(bus.csr_wr_addr);
      wr_log_d.push_back(bus.csr_wr_data);
    end
    if (!bus.csr_wr_en && (bus.csr_wr_addr != '0 || bus.csr_wr_data != '0)) gate_viol++;
    if (!bus.redirect_valid && bus.redirect_pc != '0) gate_viol++;
  end

  // Reference model: architectural CSR contents and the write list each event should produce.
  logic [31:0] model [0:4095];
  logic [11:0] exp_a [$];
  logic [31:0] exp_d [$];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] trap_status(input logic [31:0] s);
    return (s & ~32'h0000_1888) | 32'h0000_1800 | ((s & 32'h8) << 4);
  endfunction

  function automatic logic [31:0] mret_status(input logic [31:0] s);
    return (s & ~32'h0000_1888) | 32'h0000_1880 | ((s & 32'h80) >> 4);
  endfunction

  task automatic expect_wr(input logic [11:0] a, input logic [31:0] d);
    exp_a.push_back(a);
    exp_d.push_back(d);
    model[a] = d;
  endtask

  task automatic plan(input logic [1:0] tt, input logic [31:0] pc,
                      output int lat, output logic [31:0] tgt);
    if (tt == 2'b11) begin
      expect_wr(MSTATUS, mret_status(model[MSTATUS]));
      tgt = model[MEPC];
      lat = 3;
    end else begin
      expect_wr(MEPC, pc);
      expect_wr(MCAUSE, (tt == 2'b10) ? 32'd3 : 32'd11);
`ifdef TRAP_MTVAL_EN
      expect_wr(MTVAL, (tt == 2'b10) ? pc : 32'd0);
`endif
      expect_wr(MSTATUS, trap_status(model[MSTATUS]));
      tgt = model[MTVEC] & ~32'h3;
      lat = TRAP_LAT;
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_addr = a; pre_data = d; pre_en = 1'b1;
    model[a] = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic present(input logic [1:0] tt, input logic [31:0] pc, input string tag);
    @(negedge clk);
    bus.trap_valid = 1'b1; bus.trap_type = tt; bus.trap_pc = pc;
    #1;
    checks++;
    if (bus.trap_ready !== 1'b1 || bus.stall !== 1'b1) begin
      errors++;
      $display("FAIL %s accept: ready=%b stall=%b, required ready=1 stall=1", tag, bus.trap_ready, bus.stall);
    end
  endtask

  task automatic follow(input int lat, input logic [31:0] tgt, input string tag);
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin bus.trap_valid = 1'b0; bus.trap_type = 2'b00; end
      #1;
      checks++;
      if (bus.redirect_valid !== 1'(k == lat)) begin
        errors++;
        $display("FAIL %s redirect_valid cyc%0d: got %b required %b", tag, k, bus.redirect_valid, k == lat);
      end
      if (k == lat) begin
        checks++;
        if (bus.redirect_pc !== tgt) begin
          errors++;
          $display("FAIL %s redirect_pc: got %h required %h", tag, bus.redirect_pc, tgt);
        end
      end
      checks++;
      if (bus.trap_ready !== 1'(k == lat + 1)) begin
        errors++;
        $display("FAIL %s trap_ready cyc%0d: got %b required %b", tag, k, bus.trap_ready, k == lat + 1);
      end
      checks++;
      if (bus.stall !== 1'(k <= lat)) begin
        errors++;
        $display("FAIL %s stall cyc%0d: got %b required %b", tag, k, bus.stall, k <= lat);
      end
    end
  endtask

  task automatic check_writes(input string tag);
    checks++;
    if (wr_log_a.size() != exp_a.size()) begin
      errors++;
      $display("FAIL %s write count: got %0d required %0d", tag, wr_log_a.size(), exp_a.size());
    end else begin
      foreach (exp_a[i]) begin
        checks++;
        if (wr_log_a[i] !== exp_a[i] || wr_log_d[i] !== exp_d[i]) begin
          errors++;
          $display("FAIL %s write %0d: got %h=%h required %h=%h", tag, i, wr_log_a[i], wr_log_d[i], exp_a[i], exp_d[i]);
        end
      end
    end
    foreach (exp_a[i]) begin
      checks++;
      if (csr_mem[exp_a[i]] !== model[exp_a[i]]) begin
        errors++;
        $display("FAIL %s csr %h: got %h required %h", tag, exp_a[i], csr_mem[exp_a[i]], model[exp_a[i]]);
      end
    end
    wr_log_a.delete(); wr_log_d.delete();
    exp_a.delete(); exp_d.delete();
  endtask

  task automatic run_event(input logic [1:0] tt, input logic [31:0] pc, input string tag);
    int lat;
    logic [31:0] tgt;
    plan(tt, pc, lat, tgt);
    wr_log_a.delete(); wr_log_d.delete();
    present(tt, pc, tag);
    follow(lat, tgt, tag);
    check_writes(tag);
  endtask

  task automatic test_reset;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.trap_ready !== 1'b1 || bus.stall !== 1'b0 || bus.csr_wr_en !== 1'b0 ||
        bus.redirect_valid !== 1'b0 || bus.csr_rd_addr !== 12'h0) begin
      errors++;
      $display("FAIL reset_state: ready=%b stall=%b wr=%b redir=%b rd=%h, required 1 0 0 0 000",
               bus.trap_ready, bus.stall, bus.csr_wr_en, bus.redirect_valid, bus.csr_rd_addr);
    end
  endtask

  task automatic test_reset_mid_trap;
    poke(MCAUSE, 32'hDEAD_BEEF);
    wr_log_a.delete(); wr_log_d.delete();
    present(2'b01, 32'h8000_0040, "rst_mid");
    @(negedge clk); bus.trap_valid = 1'b0; bus.trap_type = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.csr_wr_en !== 1'b0 || bus.redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid outputs: wr=%b redir=%b required 0 0", bus.csr_wr_en, bus.redirect_valid);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.trap_ready !== 1'b1 || bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid idle: ready=%b stall=%b required 1 0", bus.trap_ready, bus.stall);
    end
    @(negedge clk); rst = 1'b0;
    repeat (6) @(negedge clk);
    model[MEPC] = 32'h8000_0040;
    checks++;
    if (wr_log_a.size() != 1 || csr_mem[MEPC] !== 32'h8000_0040 || csr_mem[MCAUSE] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rst_mid csrs: writes=%0d mepc=%h mcause=%h required 1 80000040 deadbeef",
               wr_log_a.size(), csr_mem[MEPC], csr_mem[MCAUSE]);
    end
    wr_log_a.delete(); wr_log_d.delete();
  endtask

  task automatic test_back_to_back;
    int lat1, lat2;
    logic [31:0] tgt1, tgt2;
    poke(MEPC, 32'h8000_0100);
    plan(2'b11, 32'h0, lat1, tgt1);
    plan(2'b01, 32'h8000_0200, lat2, tgt2);
    wr_log_a.delete(); wr_log_d.delete();
    present(2'b11, 32'h0, "b2b_mret");
    for (int k = 1; k <= lat1 + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin bus.trap_valid = 1'b0; bus.trap_type = 2'b00; end
      if (k == lat1) begin bus.trap_valid = 1'b1; bus.trap_type = 2'b01; bus.trap_pc = 32'h8000_0200; end
      #1;
      checks++;
      if (bus.redirect_valid !== 1'(k == lat1) || bus.trap_ready !== 1'(k == lat1 + 1) || bus.stall !== 1'b1) begin
        errors++;
        $display("FAIL b2b cyc%0d: redir=%b ready=%b stall=%b required %b %b 1",
                 k, bus.redirect_valid, bus.trap_ready, bus.stall, k == lat1, k == lat1 + 1);
      end
      if (k == lat1) begin
        checks++;
        if (bus.redirect_pc !== tgt1) begin
          errors++;
          $display("FAIL b2b mret redirect_pc: got %h required %h", bus.redirect_pc, tgt1);
        end
      end
    end
    follow(lat2, tgt2, "b2b_ecall");
    check_writes("b2b");
  endtask

  task automatic test_ignore_none;
    wr_log_a.delete(); wr_log_d.delete();
    @(negedge clk);
    bus.trap_valid = 1'b1; bus.trap_type = 2'b00; bus.trap_pc = 32'h1234_5678;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (bus.stall !== 1'b0 || bus.trap_ready !== 1'b1 || bus.csr_wr_en !== 1'b0) begin
        errors++;
        $display("FAIL none cyc%0d: stall=%b ready=%b wr=%b required 0 1 0", k, bus.stall, bus.trap_ready, bus.csr_wr_en);
      end
      @(negedge clk);
    end
    bus.trap_valid = 1'b0;
    checks++;
    if (wr_log_a.size() != 0) begin
      errors++;
      $display("FAIL none writes: got %0d required 0", wr_log_a.size());
    end
  endtask

  task automatic test_random;
    logic [1:0] tt;
    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(0, 1) == 1) poke(MSTATUS, $urandom);
      if ($urandom_range(0, 1) == 1) poke(MTVEC, $urandom);
      if ($urandom_range(0, 2) == 0) poke(MEPC, $urandom);
      tt = 2'($urandom_range(1, 3));
      run_event(tt, $urandom, "random");
    end
  endtask

  initial begin
    bus.trap_valid = 1'b0; bus.trap_type = 2'b00; bus.trap_pc = '0;
    for (int i = 0; i < 4096; i++) begin csr_mem[i] = '0; model[i] = '0; end
    test_reset();
    test_reset_mid_trap();
    poke(MTVEC, 32'h8000_0103);
    poke(MSTATUS, 32'h0000_0008);
    run_event(2'b01, 32'h8000_0010, "ecall");
    poke(MEPC, 32'h8000_0014);
    run_event(2'b11, 32'h0, "mret");
    run_event(2'b10, 32'h8000_0020, "ebreak");
    test_back_to_back();
    test_ignore_none();
    test_random();
    checks++;
    if (gate_viol != 0) begin
      errors++;
      $display("FAIL idle_zero: got %0d nonzero idle wr/redirect values required 0", gate_viol);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/csr_trap_ctrl.md
Name: csr_trap_ctrl

Overview:
Machine-mode trap sequencer sitting between decode/execute and the CSR register file. It takes ecall/ebreak/mret events from execute and sequences the required CSR reads and writes through the CSR file's single combinational-read/single-write port. It then issues a one-cycle PC redirect to fetch and holds the pipeline stalled for the whole sequence.

Parameters:
CSR_AW, 12, CSR address width.
MCAUSE_ECALL, 32'd11, mcause value written for ecall (environment call from M-mode).
MCAUSE_EBREAK, 32'd3, mcause value written for ebreak (breakpoint).

Ports:
clk  in  1  clock, all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
trap_valid  in  1  execute presents a trap event this cycle.
trap_type  in  2  01 = ecall, 10 = ebreak, 11 = mret, 00 = none.
trap_pc  in  32  PC of the trapping instruction.
trap_ready  out  1  high only in IDLE; the event is accepted when trap_valid && trap_ready && trap_type != 00.
csr_rd_addr  out  CSR_AW  CSR read address; the CSR file returns data combinationally in the same cycle.
csr_rd_data  in  32  CSR read data.
csr_wr_en  out  1  CSR write strobe, committed at the next rising edge.
csr_wr_addr  out  CSR_AW  CSR write address.
csr_wr_data  out  32  CSR write data.
redirect_valid  out  1  one-cycle pulse telling fetch to load redirect_pc.
redirect_pc  out  32  new PC; valid only while redirect_valid is high.
stall  out  1  freezes fetch and decode.

Behaviour:
- CSR addresses: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342, mtval 0x343.
- Reset (rst high at a rising edge):
  - state goes to IDLE; the latched PC, type and target clear to 0.
  - all outputs are 0 except trap_ready = 1.
  - Reset mid-sequence abandons it: no further CSR writes and no redirect. CSR writes already committed remain.
- Acceptance in IDLE: latch trap_pc and trap_type.
  - ecall/ebreak go to T_EPC.
  - mret goes to R_STATUS.
  - trap_type 00 with trap_valid high is ignored; state stays IDLE.
- stall = (state != IDLE) || (trap_valid && trap_type != 00). It is combinational, so the trapping instruction is frozen in the accept cycle.
- Trap path (ecall/ebreak), one state per cycle:
  - T_EPC: wr mepc = latched pc.
  - T_CAUSE: wr mcause = MCAUSE_ECALL or MCAUSE_EBREAK according to the latched type.
  - T_STATUS: rd mstatus. Write mstatus with:
    - bit7 (MPIE) = old bit3 (MIE);
    - bit3 = 0;
    - bits12:11 (MPP) = 2'b11;
    - all other bits unchanged.
  - T_VEC: rd mtvec; latch target = {mtvec[31:2], 2'b00}. Direct mode only; mode bits are ignored. No write.
  - REDIR: redirect_valid = 1, redirect_pc = target; then go to IDLE.
- Return path (mret):
  - R_STATUS: rd mstatus. Write mstatus with:
    - bit3 = old bit7;
    - bit7 = 1;
    - bits12:11 = 2'b11;
    - all other bits unchanged.
  - R_EPC: rd mepc; latch target = mepc. No write.
  - REDIR: as above.
- Latency (accept edge = cycle 0):
  - trap: redirect_valid high in cycle 5; trap_ready high again in cycle 6.
  - mret: redirect_valid in cycle 3; trap_ready in cycle 4.
- Outside T_EPC, T_CAUSE, T_STATUS and R_STATUS: csr_wr_en = 0, and csr_wr_addr/csr_wr_data are 0.
- csr_rd_addr is 0 in states that perform no read.
- At most one CSR write per cycle. Read-modify-write of mstatus completes within one cycle, because the read is combinational and the write commits at the edge.
- trap_valid asserted while not IDLE is not accepted (trap_ready = 0). Execute must hold it, and it is accepted on the first IDLE cycle.
- A back-to-back trap presented during the REDIR cycle is accepted in the following IDLE cycle, not in REDIR.

Optional Feature:
TRAP_MTVAL_EN.
- Defined: an extra state T_TVAL between T_CAUSE and T_STATUS writes mtval (0x343). It writes 0 for ecall and the latched pc for ebreak. Trap-path redirect moves to cycle 6 and trap_ready returns in cycle 7.
- Undefined: no T_TVAL state exists and mtval is never written.
- mret timing is identical in both builds.

Test Plan:
1. Reset: hold rst for 2 cycles mid-trap (in T_CAUSE) -> no further csr_wr_en, redirect_valid = 0, trap_ready = 1, mcause unchanged.
2. ecall, trap_pc = 0x8000_0010, mtvec = 0x8000_0103, mstatus = 0x0000_0008:
   - mepc = 0x8000_0010, mcause = 11, mstatus = 0x0000_1880;
   - redirect_valid high in cycle 5 only, redirect_pc = 0x8000_0100;
   - stall high in cycles 0-5.
3. mret after test 2, mepc rewritten to 0x8000_0014 -> mstatus = 0x0000_1888, redirect_pc = 0x8000_0014 in cycle 3, trap_ready high in cycle 4.
4. ebreak at pc 0x8000_0020 -> mcause = 3; with TRAP_MTVAL_EN, mtval = 0x8000_0020 and redirect in cycle 6.
5. trap_valid held high with ecall arriving in the REDIR cycle of an mret -> accepted the next cycle; a single T_EPC write of the new pc; no lost or duplicate writes.
6. trap_valid = 1 with trap_type = 00 -> stall = 0, no CSR write, state stays IDLE.
